// File: rtl/serial_frame_collector.sv
// ============================================================================
// serial_frame_collector
//
// Purpose:
//     Consumes a one-bit-per-cycle serial stream, hunts for a sync word, then
//     packs the following bits into WIDTH-bit words. A frame is one sync word
//     followed by FRAME_WORDS data words, after which hunting resumes. A single
//     output register absorbs consumer stalls; a completed word that would
//     overwrite an unaccepted one is dropped, flagged, and the frame abandoned.
//
// Parameters:
//     WIDTH       - bits per word and width of the sync pattern (>= 2)
//     SYNC_WORD   - sync pattern in natural word order
//     FRAME_WORDS - data words per frame after the sync word (>= 1)
//     MSB_FIRST   - 1: first received bit lands in bit WIDTH-1; 0: in bit 0
//
// Ports:
//     i_clk        - clock, rising edge
//     i_rst        - synchronous active-high reset
//     i_ser_in     - serial data bit
//     i_ser_valid  - i_ser_in valid this cycle (no upstream backpressure)
//     o_word_data  - assembled data word
//     o_word_valid - o_word_data valid
//     i_word_ready - consumer accepts when o_word_valid && i_word_ready
//     o_word_last  - word is the final one of its frame (qualified by valid)
//     o_locked     - high while collecting a frame
//     o_overflow   - one-cycle pulse when a completed word is dropped
// ============================================================================
module serial_frame_collector #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD   = 8'hA5,
    parameter int               FRAME_WORDS = 4,
    parameter bit               MSB_FIRST   = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ser_in,
    input  logic             i_ser_valid,
    output logic [WIDTH-1:0] o_word_data,
    output logic             o_word_valid,
    input  logic             i_word_ready,
    output logic             o_word_last,
    output logic             o_locked,
    output logic             o_overflow
);

    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(FRAME_WORDS + 1);
    localparam int FW = $clog2(WIDTH + 1);

    localparam logic [BW-1:0] C_BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [BW-1:0] C_BIT_ONE   = BW'(1);
    localparam logic [CW-1:0] C_WORD_LAST = CW'(FRAME_WORDS - 1);
    localparam logic [CW-1:0] C_WORD_ONE  = CW'(1);
    localparam logic [FW-1:0] C_FILL_FULL = FW'(WIDTH);
    localparam logic [FW-1:0] C_FILL_ONE  = FW'(1);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    // One shift register serves as the sync window in HUNT and as the word
    // assembly register in COLLECT; after a match bit_cnt restarts at zero, so
    // every collected word is built from WIDTH fresh bits.
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [FW-1:0]    r_fill_cnt;
    logic [FW-1:0]    w_fill_next;
    logic [BW-1:0]    r_bit_cnt;
    logic [CW-1:0]    r_word_cnt;

    logic [WIDTH-1:0] r_word_data;
    logic             r_word_valid;
    logic             r_word_last;
    logic             r_overflow;

    logic             w_match;
    logic             w_word_done;
    logic             w_word_is_last;
    logic             w_accept;
    logic             w_load;
    logic             w_drop;

    // Post-shift view of the window/assembly register for the current bit.
    always_comb begin
        w_shift_next = r_shift;
        if (MSB_FIRST) begin
            w_shift_next = {r_shift[WIDTH-2:0], i_ser_in};
        end else begin
            w_shift_next = {i_ser_in, r_shift[WIDTH-1:1]};
        end
    end

    // The fill count guards against matching on stale window contents left
    // over from reset or from the previous frame.
    assign w_fill_next    = (r_fill_cnt == C_FILL_FULL) ? r_fill_cnt
                                                        : r_fill_cnt + C_FILL_ONE;
    assign w_match        = (r_state == HUNT) && i_ser_valid &&
                            (w_shift_next == SYNC_WORD) && (w_fill_next == C_FILL_FULL);
    assign w_word_done    = (r_state == COLLECT) && i_ser_valid && (r_bit_cnt == C_BIT_LAST);
    assign w_word_is_last = (r_word_cnt == C_WORD_LAST);
    assign w_accept       = r_word_valid && i_word_ready;
    assign w_load         = w_word_done && (!r_word_valid || i_word_ready);
    assign w_drop         = w_word_done && r_word_valid && !i_word_ready;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a dropped word abandons the frame just like the final
    // word ends it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HUNT: begin
                if (w_match) begin
                    w_state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (w_word_done && (w_word_is_last || w_drop)) begin
                    w_state_next = HUNT;
                end
            end
            default: w_state_next = HUNT;
        endcase
    end

    // Datapath: shift register, counters and the one-entry output register.
    // fill_cnt is held at zero throughout COLLECT, so re-entering HUNT always
    // starts a fresh WIDTH-bit fill.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift      <= '0;
            r_fill_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_word_last  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (i_ser_valid) begin
                r_shift <= w_shift_next;
            end

            if (r_state == HUNT) begin
                if (i_ser_valid) begin
                    r_fill_cnt <= w_match ? '0 : w_fill_next;
                end
                if (w_match) begin
                    r_bit_cnt  <= '0;
                    r_word_cnt <= '0;
                end
            end else begin
                r_fill_cnt <= '0;
                if (i_ser_valid) begin
                    r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + C_BIT_ONE;
                end
                if (w_word_done) begin
                    r_word_cnt <= r_word_cnt + C_WORD_ONE;
                end
            end

            if (w_load) begin
                r_word_data  <= w_shift_next;
                r_word_valid <= 1'b1;
                r_word_last  <= w_word_is_last;
            end else if (w_accept) begin
                r_word_valid <= 1'b0;
                r_word_last  <= 1'b0;
            end

            r_overflow <= w_drop;
        end
    end

    // Output decode; every output comes straight from a register.
    always_comb begin
        o_locked     = (r_state == COLLECT);
        o_word_data  = r_word_data;
        o_word_valid = r_word_valid;
        o_word_last  = r_word_last;
        o_overflow   = r_overflow;
    end

endmodule

// File: tb/tb_serial_frame_collector.sv
// ============================================================================
// tb_serial_frame_collector
//
// Purpose:
//     Directed bench for serial_frame_collector. A table of whole-frame vectors
//     (sync alignment, continuous and gapped input) is replayed in a loop, then
//     hand-written sequences cover backpressure/overflow, simultaneous accept
//     and completion, re-hunt after a frame, reset mid-frame and LSB-first order.
//
// Ports: none (top-level bench).
// ============================================================================
module tb_serial_frame_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       serIn;
    logic       serValid;
    logic       wordReady;

    logic [7:0] wordData;
    logic       wordValid;
    logic       wordLast;
    logic       locked;
    logic       overflow;

    logic [7:0] lsbData;
    logic       lsbValid;
    logic       lsbLast;
    logic       lsbLocked;
    logic       lsbOverflow;

    int nChecks = 0;
    int nPass   = 0;

    // Whole-frame vectors: optional 4-bit prefix, sync A5, two data words.
    typedef struct {
        int         prefixLen;
        logic [3:0] prefix;
        logic [7:0] word0;
        logic [7:0] word1;
        bit         gapped;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } frameVec_t;

    frameVec_t vectors[5];

    always #5 clk = ~clk;

    serial_frame_collector #(
        .WIDTH(8), .SYNC_WORD(8'hA5), .FRAME_WORDS(2), .MSB_FIRST(1'b1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_ser_in(serIn), .i_ser_valid(serValid),
        .o_word_data(wordData), .o_word_valid(wordValid), .i_word_ready(wordReady),
        .o_word_last(wordLast), .o_locked(locked), .o_overflow(overflow)
    );

    serial_frame_collector #(
        .WIDTH(8), .SYNC_WORD(8'hA5), .FRAME_WORDS(2), .MSB_FIRST(1'b0)
    ) dutLsb (
        .i_clk(clk), .i_rst(rst), .i_ser_in(serIn), .i_ser_valid(serValid),
        .o_word_data(lsbData), .o_word_valid(lsbValid), .i_word_ready(wordReady),
        .o_word_last(lsbLast), .o_locked(lsbLocked), .o_overflow(lsbOverflow)
    );

    // Single comparison: counts, and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Full output check of the MSB-first instance.
    task automatic checkMsb(input string tag, input logic v, input logic [7:0] d,
                            input logic l, input logic lk, input logic ov);
        checkOutput($sformatf("%s valid", tag), {31'd0, wordValid}, {31'd0, v});
        checkOutput($sformatf("%s data", tag), {24'd0, wordData}, {24'd0, d});
        checkOutput($sformatf("%s last", tag), {31'd0, wordLast}, {31'd0, l});
        checkOutput($sformatf("%s locked", tag), {31'd0, locked}, {31'd0, lk});
        checkOutput($sformatf("%s overflow", tag), {31'd0, overflow}, {31'd0, ov});
    endtask

    // Drive one cycle of serial input at the falling edge, sample 1ns after the
    // following rising edge.
    task automatic applyStimulus(input logic ser, input logic vld);
        @(negedge clk);
        serIn    = ser;
        serValid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input logic b, input bit gapped);
        if (gapped) begin
            applyStimulus(1'b0, 1'b0);
        end
        applyStimulus(b, 1'b1);
    endtask

    task automatic sendMsb(input logic [7:0] b, input int hi, input int lo, input bit gapped);
        for (int i = hi; i >= lo; i--) begin
            sendBit(b[i], gapped);
        end
    endtask

    task automatic sendLsb(input logic [7:0] b, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            sendBit(b[i], 1'b0);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        serValid = 1'b0;
        serIn    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Sends sync then two words MSB-first with ready high, checking timing.
    task automatic sendFrame(input logic [7:0] w0, input logic [7:0] w1, input string tag);
        sendMsb(8'hA5, 7, 0, 1'b0);
        checkOutput({tag, " sync locked"}, {31'd0, locked}, 32'd1);
        sendMsb(w0, 7, 0, 1'b0);
        checkMsb({tag, " w0"}, 1'b1, w0, 1'b0, 1'b1, 1'b0);
        sendMsb(w1, 7, 0, 1'b0);
        checkMsb({tag, " w1"}, 1'b1, w1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        vectors[0] = '{prefixLen: 0, prefix: 4'h0, word0: 8'h3C, word1: 8'hC3, gapped: 1'b0, exp0: 8'h3C, exp1: 8'hC3};
        vectors[1] = '{prefixLen: 4, prefix: 4'h5, word0: 8'h11, word1: 8'h22, gapped: 1'b0, exp0: 8'h11, exp1: 8'h22};
        vectors[2] = '{prefixLen: 0, prefix: 4'h0, word0: 8'h3C, word1: 8'hC3, gapped: 1'b1, exp0: 8'h3C, exp1: 8'hC3};
        vectors[3] = '{prefixLen: 4, prefix: 4'h5, word0: 8'h11, word1: 8'h22, gapped: 1'b1, exp0: 8'h11, exp1: 8'h22};
        vectors[4] = '{prefixLen: 4, prefix: 4'hA, word0: 8'h00, word1: 8'hFF, gapped: 1'b0, exp0: 8'h00, exp1: 8'hFF};

        rst       = 1'b0;
        serIn     = 1'b0;
        serValid  = 1'b0;
        wordReady = 1'b1;

        for (int r = 0; r < 5; r++) begin
            string tag;
            tag = $sformatf("vec%0d", r);
            wordReady = 1'b1;
            doReset();
            checkMsb({tag, " reset"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            if (vectors[r].prefixLen > 0) begin
                sendMsb({4'h0, vectors[r].prefix}, 3, 0, vectors[r].gapped);
            end
            sendMsb(8'hA5, 7, 1, vectors[r].gapped);
            checkOutput({tag, " pre-sync locked"}, {31'd0, locked}, 32'd0);
            sendMsb(8'hA5, 0, 0, vectors[r].gapped);
            checkOutput({tag, " sync locked"}, {31'd0, locked}, 32'd1);
            sendMsb(vectors[r].word0, 7, 1, vectors[r].gapped);
            checkOutput({tag, " w0 early valid"}, {31'd0, wordValid}, 32'd0);
            sendMsb(vectors[r].word0, 0, 0, vectors[r].gapped);
            checkMsb({tag, " w0"}, 1'b1, vectors[r].exp0, 1'b0, 1'b1, 1'b0);
            sendMsb(vectors[r].word1, 7, 1, vectors[r].gapped);
            checkOutput({tag, " w1 early valid"}, {31'd0, wordValid}, 32'd0);
            sendMsb(vectors[r].word1, 0, 0, vectors[r].gapped);
            checkMsb({tag, " w1"}, 1'b1, vectors[r].exp1, 1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0);
            checkOutput({tag, " post valid"}, {31'd0, wordValid}, 32'd0);
            checkOutput({tag, " post last"}, {31'd0, wordLast}, 32'd0);
        end

        // Backpressure: first word held, second dropped with a single pulse.
        doReset();
        wordReady = 1'b0;
        sendMsb(8'hA5, 7, 0, 1'b0);
        sendMsb(8'h11, 7, 0, 1'b0);
        checkMsb("bp w0", 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        sendMsb(8'h22, 7, 1, 1'b0);
        checkMsb("bp hold", 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        sendMsb(8'h22, 0, 0, 1'b0);
        checkMsb("bp drop", 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkMsb("bp after", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        wordReady = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkMsb("bp accepted", 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h33, 8'h44, "bp next");

        // Accept of the pending word on the same edge the next word completes.
        doReset();
        wordReady = 1'b0;
        sendMsb(8'hA5, 7, 0, 1'b0);
        sendMsb(8'h11, 7, 0, 1'b0);
        sendMsb(8'h22, 7, 1, 1'b0);
        wordReady = 1'b1;
        sendMsb(8'h22, 0, 0, 1'b0);
        checkMsb("simul", 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("simul drained", {31'd0, wordValid}, 32'd0);

        // Re-hunt: the last data word 52 plus a single 1 bit forms A5 in the
        // window, which must not count as sync.
        doReset();
        sendFrame(8'h11, 8'h52, "rehunt");
        sendMsb(8'hA5, 7, 7, 1'b0);
        checkOutput("rehunt stale window", {31'd0, locked}, 32'd0);
        sendMsb(8'hA5, 6, 0, 1'b0);
        checkOutput("rehunt fresh sync", {31'd0, locked}, 32'd1);

        // Reset mid-frame with a pending word, then a clean frame.
        doReset();
        wordReady = 1'b0;
        sendMsb(8'hA5, 7, 0, 1'b0);
        sendMsb(8'h11, 7, 0, 1'b0);
        sendMsb(8'h55, 7, 5, 1'b0);
        doReset();
        checkMsb("midrst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        wordReady = 1'b1;
        sendFrame(8'h55, 8'h66, "midrst next");

        // LSB-first instance: sync bits 1,0,1,0,0,1,0,1 then words 12, C1.
        doReset();
        sendLsb(8'hA5, 0, 6);
        checkOutput("lsb pre-sync locked", {31'd0, lsbLocked}, 32'd0);
        sendLsb(8'hA5, 7, 7);
        checkOutput("lsb sync locked", {31'd0, lsbLocked}, 32'd1);
        sendLsb(8'h12, 0, 7);
        checkOutput("lsb w0 valid", {31'd0, lsbValid}, 32'd1);
        checkOutput("lsb w0 data", {24'd0, lsbData}, 32'h12);
        checkOutput("lsb w0 last", {31'd0, lsbLast}, 32'd0);
        sendLsb(8'hC1, 0, 7);
        checkOutput("lsb w1 valid", {31'd0, lsbValid}, 32'd1);
        checkOutput("lsb w1 data", {24'd0, lsbData}, 32'hC1);
        checkOutput("lsb w1 last", {31'd0, lsbLast}, 32'd1);
        checkOutput("lsb w1 locked", {31'd0, lsbLocked}, 32'd0);
        checkOutput("lsb overflow", {31'd0, lsbOverflow}, 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
